// File: rtl/hazard_pkg.sv
// Shared types, bypass encodings and the saturating-increment helper for the hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {StInit, StRun, StMemWait} state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Increment val but stick at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// EX operand bypass select: the youngest producer (MEM) wins over WB; x0 never forwards.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  input  logic [4:0] wb_rd,
  input  logic       wb_wen,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bypass sequencing for the 5-stage pipeline, with post-reset drain and perf counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wen,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_wen,
  input  logic             cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             init_done,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mw,
  output logic [CNT_W-1:0] cnt_fl
);

  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] InitLoad = InitW'(INIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_mw_q, cnt_mw_d, cnt_fl_q, cnt_fl_d;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             freeze, load_use, lu_evt, mw_evt, fl_evt;

  fwd_select u_fwd_a (
    .ex_rs   (ex_rs1),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .sel     (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .ex_rs   (ex_rs2),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_wen),
    .sel     (fwd_b_raw)
  );

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
  // Once waiting, only mem_ready releases the freeze.
  assign freeze   = (state_q == StMemWait) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    pc_redirect = 1'b0;
    fwd_a_sel   = FWD_REG;
    fwd_b_sel   = FWD_REG;
    init_done   = 1'b0;
    lu_evt      = 1'b0;
    mw_evt      = 1'b0;
    fl_evt      = 1'b0;
    case (state_q)
      StInit: begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
        if (init_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end
      StRun, StMemWait: begin
        init_done = 1'b1;
        fwd_a_sel = fwd_a_raw;
        fwd_b_sel = fwd_b_raw;
        if (freeze) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          mw_evt    = 1'b1;
          state_d   = StMemWait;
        end else begin
          state_d = StRun;
          if (ex_redirect) begin
            pc_redirect = 1'b1;
            flush_id    = 1'b1;
            flush_ex    = 1'b1;
            fl_evt      = 1'b1;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            lu_evt   = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    cnt_lu_d = cnt_lu_q;
    cnt_mw_d = cnt_mw_q;
    cnt_fl_d = cnt_fl_q;
    if (cnt_clr) begin
      cnt_lu_d = '0;
      cnt_mw_d = '0;
      cnt_fl_d = '0;
    end else begin
      if (lu_evt) cnt_lu_d = CNT_W'(sat_inc(32'(cnt_lu_q), CNT_W));
      if (mw_evt) cnt_mw_d = CNT_W'(sat_inc(32'(cnt_mw_q), CNT_W));
      if (fl_evt) cnt_fl_d = CNT_W'(sat_inc(32'(cnt_fl_q), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= InitLoad;
      cnt_lu_q   <= '0;
      cnt_mw_q   <= '0;
      cnt_fl_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cnt_lu_q   <= cnt_lu_d;
      cnt_mw_q   <= cnt_mw_d;
      cnt_fl_q   <= cnt_fl_d;
    end
  end

  assign cnt_lu = cnt_lu_q;
  assign cnt_mw = cnt_mw_q;
  assign cnt_fl = cnt_fl_q;

endmodule
